mi_regfile_slave: RTL

- MI responder (slave end) terminating an MI bus segment on a bank of REG_COUNT DATA_WIDTH-bit registers.
- Accepts reads and writes, returns in-order read data after a fixed READ_LATENCY.
- Exposes control registers to fabric logic and samples status inputs from it.
- Sits behind the MI splitter/async bridge as the leaf of the CSR tree.

---
 rtl/mi_regfile_pkg.sv | 40 ++++
 rtl/mi_rd_pipe.sv | 42 ++++
 rtl/mi_regfile_slave.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mi_regfile_pkg.sv
// mi_regfile_pkg
//   Shared definitions for the MI register-file responder.
//   - READ_LATENCY_MIN / READ_LATENCY_MAX : legal range of the read pipe depth
//   - idx_t / addr2idx()                  : byte address -> word index decode
//   The read-pipe stage record {valid, data} depends on DATA_WIDTH, so it is
//   declared next to its only user in mi_rd_pipe.
package mi_regfile_pkg;

   localparam int READ_LATENCY_MIN = 1;
   localparam int READ_LATENCY_MAX = 4;

   // idx is wide enough for the largest bank (256 registers).
   typedef struct packed {
      logic       in_range;
      logic [7:0] idx;
   } idx_t;

   // dw is the data width in bits and must be a power-of-two multiple of 8.
   // The subtraction is done at 64 bits, so an address below base wraps to
   // a huge word offset and naturally lands out of range.
   function automatic idx_t addr2idx(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input int          dw,
                                     input int          count);
      logic [63:0] off;
      logic [63:0] word;
      int          sh;
      idx_t        r;
      off = addr - base;
      sh  = 0;
      for (int s = 0; s < 8; s++) begin
         if ((dw / 8) == (1 << s)) sh = s;
      end
      word       = off >> sh;
      r.in_range = (word < 64'(count));
      r.idx      = word[7:0];
      return r;
   endfunction

endpackage

// File: rtl/mi_rd_pipe.sv
// mi_rd_pipe
//   READ_LATENCY-deep shift register of {valid, data} read responses.
//   Ports:
//     CLK, RESET_N      : clock, asynchronous active-low reset (flushes all stages)
//     in_valid, in_data : read response captured at the accept edge
//     DRDY, DRD         : response leaving the last stage; DRD is 0 whenever DRDY is 0
module mi_rd_pipe #(
   parameter int DATA_WIDTH   = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  DRDY,
   output logic [DATA_WIDTH-1:0] DRD
);

   typedef struct packed {
      logic                  valid;
      logic [DATA_WIDTH-1:0] data;
   } rd_stage_t;

   rd_stage_t [READ_LATENCY-1:0] pipe_q;

   // Data is zeroed at entry for invalid slots, so DRD needs no output gating.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         pipe_q <= '0;
      end else begin
         pipe_q[0].valid <= in_valid;
         pipe_q[0].data  <= in_valid ? in_data : '0;
         for (int k = 1; k < READ_LATENCY; k++) begin
            pipe_q[k] <= pipe_q[k-1];
         end
      end
   end

   assign DRDY = pipe_q[READ_LATENCY-1].valid;
   assign DRD  = pipe_q[READ_LATENCY-1].data;

endmodule

// File: rtl/mi_regfile_slave.sv
// mi_regfile_slave
//   Leaf MI responder: a bank of REG_COUNT DATA_WIDTH-bit registers.
//   RW registers are written through MI and driven out on CTRL_OUT with a
//   one-cycle CTRL_WE pulse; RO registers (RO_MASK bit set) read STAT_IN.
//   Ports:
//     CLK, RESET_N       : clock, asynchronous active-low reset
//     ADDR, BE, WR, DWR  : MI write request (byte address, byte enables, data)
//     RD                 : MI read request
//     ARDY               : request accepted (1 from the first edge after reset)
//     DRD, DRDY          : read data, READ_LATENCY cycles after accept
//     STAT_IN            : status slices for RO registers
//     CTRL_OUT, CTRL_WE  : RW register values and per-register write pulse
//     ERR_CNT            : only with MI_REGFILE_ERR_CNT_EN defined; saturating
//                          count of out-of-range accesses and RD+WR collisions
module mi_regfile_slave
   import mi_regfile_pkg::*;
#(
   parameter int                      DATA_WIDTH   = 32,
   parameter int                      ADDR_WIDTH   = 32,
   parameter int                      REG_COUNT    = 16,
   parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR    = '0,
   parameter int                      READ_LATENCY = 1,
   parameter logic [REG_COUNT-1:0]    RO_MASK      = '0
) (
   input  logic                            CLK,
   input  logic                            RESET_N,
   input  logic [ADDR_WIDTH-1:0]           ADDR,
   input  logic [DATA_WIDTH/8-1:0]         BE,
   input  logic                            WR,
   input  logic [DATA_WIDTH-1:0]           DWR,
   input  logic                            RD,
   output logic                            ARDY,
   output logic [DATA_WIDTH-1:0]           DRD,
   output logic                            DRDY,
   input  logic [REG_COUNT*DATA_WIDTH-1:0] STAT_IN,
   output logic [REG_COUNT*DATA_WIDTH-1:0] CTRL_OUT,
   output logic [REG_COUNT-1:0]            CTRL_WE
`ifdef MI_REGFILE_ERR_CNT_EN
   ,
   output logic [15:0]                     ERR_CNT
`endif
);

   localparam int NB = DATA_WIDTH / 8;

   logic                  ardy_q;
   logic                  accept;
   idx_t                  dec;
   logic [REG_COUNT-1:0]  hit;
   logic [DATA_WIDTH-1:0] rd_sel;
   logic                  rd_valid;
   logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
   logic [REG_COUNT-1:0]  we_q;

   // No backpressure: ready simply comes up one edge after reset release.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) ardy_q <= 1'b0;
      else          ardy_q <= 1'b1;
   end

   assign ARDY   = ardy_q;
   assign accept = ardy_q & (RD | WR);

   always_comb begin
      dec = addr2idx(64'(ADDR), 64'(BASE_ADDR), DATA_WIDTH, REG_COUNT);
   end

   // One-hot register select plus read mux; out-of-range leaves rd_sel at 0.
   always_comb begin
      hit    = '0;
      rd_sel = '0;
      for (int i = 0; i < REG_COUNT; i++) begin
         if (dec.in_range && (dec.idx == 8'(i))) begin
            hit[i] = 1'b1;
            rd_sel = RO_MASK[i] ? STAT_IN[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
         end
      end
   end

   // RD+WR together is handled as a write, so it never produces a response.
   assign rd_valid = accept & RD & ~WR;

   // RO registers are never written, so their flops stay at reset and are
   // trimmed away; CTRL_OUT masks them to 0 regardless.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
         we_q <= '0;
      end else begin
         we_q <= '0;
         for (int i = 0; i < REG_COUNT; i++) begin
            if (accept && WR && hit[i] && !RO_MASK[i]) begin
               we_q[i] <= 1'b1;
               for (int b = 0; b < NB; b++) begin
                  if (BE[b]) regs_q[i][b*8 +: 8] <= DWR[b*8 +: 8];
               end
            end
         end
      end
   end

   always_comb begin
      CTRL_OUT = '0;
      for (int i = 0; i < REG_COUNT; i++) begin
         CTRL_OUT[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs_q[i];
      end
   end

   assign CTRL_WE = we_q;

   mi_rd_pipe #(
      .DATA_WIDTH   (DATA_WIDTH),
      .READ_LATENCY (READ_LATENCY)
   ) u_rd_pipe (
      .CLK      (CLK),
      .RESET_N  (RESET_N),
      .in_valid (rd_valid),
      .in_data  (rd_sel),
      .DRDY     (DRDY),
      .DRD      (DRD)
   );

`ifdef MI_REGFILE_ERR_CNT_EN
   logic        err_evt;
   logic [15:0] err_cnt_q;

   // A collision that is also out of range still counts once.
   assign err_evt = accept & (~dec.in_range | (RD & WR));

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         err_cnt_q <= '0;
      end else if (err_evt && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_q <= err_cnt_q + 16'd1;
      end
   end

   assign ERR_CNT = err_cnt_q;
`endif

endmodule
